// File: rtl/fp_add_pkg.sv
// Shared types and constants for the FP add/sub pipeline scheduler.
// The stage metadata record travels with each op from issue to result.
package fp_add_pkg;

   localparam int FP_ID_W = 5;

   typedef enum logic {
      SRC_FPU = 1'b0,
      SRC_FMA = 1'b1
   } fp_src_e;

   typedef struct packed {
      logic               v;
      fp_src_e            src;
      logic [FP_ID_W-1:0] id;
      logic               sub;
      logic [2:0]         rm;
   } fp_stage_meta_t;

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Grants only while en is high; the preference
// pointer moves only when upd confirms that the grant was taken.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic       upd,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // ptr_q names the requester that wins a tie
   logic ptr_q, ptr_d;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         gnt[0] = req[0] & (~req[1] | ~ptr_q);
         gnt[1] = req[1] & (~req[0] |  ptr_q);
      end
      ptr_d = ptr_q;
      if (upd) ptr_d = gnt[0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ptr_q <= 1'b0;
      else          ptr_q <= ptr_d;
   end

endmodule

// File: rtl/fp_addsub_sched.sv
// Issue scheduler for the shared FP add/sub datapath: arbitrates two requesters,
// carries per-stage metadata, stalls globally on output back-pressure, handles flush.
module fp_addsub_sched
   import fp_add_pkg::*;
#(
   parameter int STAGES = 4,
   parameter int ID_W   = FP_ID_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [1:0]        req_sub,
   input  logic [2:0]        req_rm0,
   input  logic [2:0]        req_rm1,
   input  logic [ID_W-1:0]   req_id0,
   input  logic [ID_W-1:0]   req_id1,
   input  logic              flush,
   output logic              issue_sel,
   output logic              issue_sub,
   output logic [STAGES-1:0] stage_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_src,
   output logic [ID_W-1:0]   out_id,
   output logic [2:0]        out_rm,
   output logic              busy
);

   fp_stage_meta_t [STAGES-1:0] meta_q, meta_d, cur;
   fp_stage_meta_t              new_op;
   logic [1:0]                  req_eff, gnt;
   logic                        advance;

   // Flush turns requester-0 entries into bubbles before anything else looks at them
   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         cur[k]   = meta_q[k];
         cur[k].v = meta_q[k].v & ~(flush & (meta_q[k].src == SRC_FPU));
         busy     = busy | meta_q[k].v;
      end
      out_valid = cur[STAGES-1].v;
      advance   = reset_n & (out_ready | ~out_valid);
      req_eff   = {req_valid[1], req_valid[0] & ~flush};
   end

   rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (advance),
      .upd     (|gnt),
      .req     (req_eff),
      .gnt     (gnt)
   );

   always_comb begin
      req_ready  = gnt;
      issue_sel  = gnt[1];
      issue_sub  = |(gnt & req_sub);
      new_op     = '0;
      new_op.v   = |gnt;
      new_op.src = fp_src_e'(gnt[1]);
      new_op.id  = gnt[1] ? req_id1 : req_id0;
      new_op.sub = issue_sub;
      new_op.rm  = gnt[1] ? req_rm1 : req_rm0;
      stage_en   = {STAGES{advance}};
      meta_d     = cur;
      if (advance) begin
         meta_d[0] = new_op;
         for (int k = 1; k < STAGES; k++) meta_d[k] = cur[k-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) meta_q <= '0;
      else          meta_q <= meta_d;
   end

   assign out_src = meta_q[STAGES-1].src;
   assign out_id  = meta_q[STAGES-1].id;
   assign out_rm  = meta_q[STAGES-1].rm;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Bench for fp_addsub_sched: directed scenario tasks plus a random run, all
// observed by a queue-based reference model of the in-order pipe.
module tb_fp_addsub_sched;

   localparam int STAGES = 4;
   localparam int ID_W   = 5;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [1:0]        req_valid, req_ready, req_sub;
   logic [2:0]        req_rm0, req_rm1;
   logic [ID_W-1:0]   req_id0, req_id1;
   logic              flush, issue_sel, issue_sub;
   logic [STAGES-1:0] stage_en;
   logic              out_valid, out_ready, out_src, busy;
   logic [ID_W-1:0]   out_id;
   logic [2:0]        out_rm;

   int npass = 0;
   int nchk  = 0;

   fp_addsub_sched #(.STAGES(STAGES), .ID_W(ID_W)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_sub(req_sub), .req_rm0(req_rm0), .req_rm1(req_rm1), .req_id0(req_id0),
      .req_id1(req_id1), .flush(flush), .issue_sel(issue_sel), .issue_sub(issue_sub),
      .stage_en(stage_en), .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
      .out_id(out_id), .out_rm(out_rm), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: ops in acceptance order, each with the number of pipe moves it has seen
   typedef struct {
      bit        src;
      logic [4:0] id;
      logic [2:0] rm;
      int        age;
   } ent_t;

   ent_t q[$];
   bit   pref;
   bit   rets[$];

   always @(negedge clk) begin
      bit ov, adv, g0, g1, esub;
      ent_t e;
      if (!reset_n) begin
         q.delete();
         pref = 1'b0;
      end else begin
         ov  = (q.size() > 0) && (q[0].age == STAGES-1) && !(flush && q[0].src == 1'b0);
         adv = out_ready || !ov;
         g0  = adv && req_valid[0] && !flush && (!req_valid[1] || !pref);
         g1  = adv && req_valid[1] && (!(req_valid[0] && !flush) || pref);
         esub = g1 ? req_sub[1] : (g0 ? req_sub[0] : 1'b0);
         nchk++;
         if (req_ready !== {g1, g0}) $display("FAIL mon_ready got=%b exp=%b t=%0t", req_ready, {g1, g0}, $time);
         else npass++;
         nchk++;
         if (out_valid !== ov) $display("FAIL mon_out_valid got=%b exp=%b t=%0t", out_valid, ov, $time);
         else npass++;
         nchk++;
         if (stage_en !== {STAGES{adv}}) $display("FAIL mon_stage_en got=%b exp=%b t=%0t", stage_en, {STAGES{adv}}, $time);
         else npass++;
         nchk++;
         if ({issue_sel, issue_sub} !== {g1, esub}) $display("FAIL mon_issue got=%b exp=%b t=%0t", {issue_sel, issue_sub}, {g1, esub}, $time);
         else npass++;
         nchk++;
         if (busy !== (q.size() != 0)) $display("FAIL mon_busy got=%b exp=%b t=%0t", busy, q.size() != 0, $time);
         else npass++;
         if (ov) begin
            nchk++;
            if ({out_src, out_id, out_rm} !== {q[0].src, q[0].id, q[0].rm})
               $display("FAIL mon_result got=%b/%0d/%0d exp=%b/%0d/%0d t=%0t", out_src, out_id, out_rm, q[0].src, q[0].id, q[0].rm, $time);
            else npass++;
         end
         if (flush)
            for (int i = q.size()-1; i >= 0; i--) if (q[i].src == 1'b0) q.delete(i);
         if (adv) begin
            if (ov) begin
               rets.push_back(q[0].src);
               void'(q.pop_front());
            end
            foreach (q[i]) q[i].age++;
            if (g0 || g1) begin
               e.src = g1;
               e.id  = g1 ? req_id1 : req_id0;
               e.rm  = g1 ? req_rm1 : req_rm0;
               e.age = 0;
               q.push_back(e);
               pref = g0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      req_valid = 2'b00;
      flush     = 1'b0;
      out_ready = 1'b1;
      #1;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      nchk++;
      if (busy) $display("FAIL drain_timeout busy=%b after %0d cycles", busy, n);
      else npass++;
   endtask

   task automatic test_reset();
      req_valid = 2'b11; out_ready = 1'b1;
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      nchk++;
      if ({req_ready, out_valid, busy, stage_en, issue_sel, issue_sub} !== '0)
         $display("FAIL reset_outputs got rdy=%b ov=%b busy=%b en=%b sel=%b sub=%b exp all 0",
                  req_ready, out_valid, busy, stage_en, issue_sel, issue_sub);
      else npass++;
      tick();
      reset_n = 1'b1;
      rets.delete();
      #1;
      nchk++;
      if (req_ready !== 2'b01) $display("FAIL reset_first_grant got=%b exp=01", req_ready);
      else npass++;
      tick();
      nchk++;
      if (req_ready !== 2'b10) $display("FAIL reset_second_grant got=%b exp=10", req_ready);
      else npass++;
      tick();
      drain();
      nchk++;
      if (rets.size() != 2) $display("FAIL reset_retire_count got=%0d exp=2", rets.size());
      else npass++;
   endtask

   task automatic test_latency();
      int n = 1;
      drain();
      req_valid = 2'b01; req_id0 = 5'd3; req_rm0 = 3'd1;
      #1;
      nchk++;
      if (req_ready !== 2'b01) $display("FAIL latency_accept got=%b exp=01", req_ready);
      else npass++;
      tick();
      req_valid = 2'b00;
      #1;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      nchk++;
      if (n != STAGES) $display("FAIL latency_cycles got=%0d exp=%0d", n, STAGES);
      else npass++;
      nchk++;
      if ({out_valid, out_src, out_id, out_rm} !== {1'b1, 1'b0, 5'd3, 3'd1})
         $display("FAIL latency_result got v=%b src=%b id=%0d rm=%0d exp v=1 src=0 id=3 rm=1", out_valid, out_src, out_id, out_rm);
      else npass++;
   endtask

   task automatic test_fairness();
      logic [1:0] g, prev;
      int c0 = 0, c1 = 0;
      drain();
      rets.delete();
      req_valid = 2'b11; req_id0 = 5'd0; req_id1 = 5'd16;
      prev = 2'b00;
      for (int c = 0; c < 8; c++) begin
         #1;
         g = req_ready;
         nchk++;
         if (!$onehot(g) || (c > 0 && g === prev)) $display("FAIL fair_alternate cycle=%0d got=%b prev=%b", c, g, prev);
         else npass++;
         if (g[0]) c0++;
         if (g[1]) c1++;
         prev = g;
         tick();
         if (g[0]) req_id0 = req_id0 + 1'b1;
         if (g[1]) req_id1 = req_id1 + 1'b1;
      end
      nchk++;
      if (c0 != 4 || c1 != 4) $display("FAIL fair_counts got=%0d/%0d exp=4/4", c0, c1);
      else npass++;
      drain();
      nchk++;
      if (rets.size() != 8) $display("FAIL fair_retired got=%0d exp=8", rets.size());
      else npass++;
   endtask

   task automatic test_backpressure();
      logic [ID_W-1:0] snap;
      drain();
      rets.delete();
      out_ready = 1'b0; req_valid = 2'b01; req_id0 = 5'd8;
      for (int c = 0; c < STAGES+3; c++) begin
         #1;
         if (req_ready[0]) begin
            tick();
            req_id0 = req_id0 + 1'b1;
         end else tick();
      end
      snap = out_id;
      for (int c = 0; c < 5; c++) begin
         #1;
         nchk++;
         if ({out_valid, stage_en, req_ready} !== {1'b1, {STAGES{1'b0}}, 2'b00} || out_id !== snap)
            $display("FAIL bp_hold cycle=%0d got v=%b en=%b rdy=%b id=%0d exp v=1 en=0 rdy=00 id=%0d",
                     c, out_valid, stage_en, req_ready, out_id, snap);
         else npass++;
         tick();
      end
      drain();
      nchk++;
      if (rets.size() != STAGES) $display("FAIL bp_retired got=%0d exp=%0d", rets.size(), STAGES);
      else npass++;
   endtask

   task automatic test_flush();
      int ones = 0;
      drain();
      rets.delete();
      for (int c = 0; c < 4; c++) begin
         req_valid = (c % 2 == 0) ? 2'b01 : 2'b10;
         req_id0 = 5'(20 + c); req_id1 = 5'(20 + c);
         tick();
      end
      req_valid = 2'b11; req_id0 = 5'd24; req_id1 = 5'd25; flush = 1'b1;
      #1;
      nchk++;
      if (req_ready !== 2'b10 || out_valid !== 1'b0)
         $display("FAIL flush_cycle got rdy=%b ov=%b exp rdy=10 ov=0", req_ready, out_valid);
      else npass++;
      tick();
      drain();
      foreach (rets[i]) if (rets[i]) ones++;
      nchk++;
      if (rets.size() != 3 || ones != 3) $display("FAIL flush_survivors got=%0d (src1=%0d) exp=3 (src1=3)", rets.size(), ones);
      else npass++;
   endtask

   task automatic test_flush_stall();
      int n = 0;
      drain();
      rets.delete();
      req_valid = 2'b01; req_id0 = 5'd30; out_ready = 1'b0;
      tick();
      req_valid = 2'b00;
      #1;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      flush = 1'b1;
      #1;
      nchk++;
      if (out_valid !== 1'b0 || stage_en !== {STAGES{1'b1}})
         $display("FAIL flush_stall got ov=%b en=%b exp ov=0 en=%b", out_valid, stage_en, {STAGES{1'b1}});
      else npass++;
      tick();
      drain();
      nchk++;
      if (rets.size() != 0) $display("FAIL flush_stall_killed got=%0d retired exp=0", rets.size());
      else npass++;
   endtask

   task automatic test_random();
      logic [1:0] hs = 2'b00;
      drain();
      for (int c = 0; c < 400; c++) begin
         if (hs[0] || !req_valid[0]) begin
            req_valid[0] = $urandom_range(0, 1);
            req_id0 = 5'($urandom); req_rm0 = 3'($urandom_range(0, 4)); req_sub[0] = 1'($urandom);
         end
         if (hs[1] || !req_valid[1]) begin
            req_valid[1] = $urandom_range(0, 1);
            req_id1 = 5'($urandom); req_rm1 = 3'($urandom_range(0, 4)); req_sub[1] = 1'($urandom);
         end
         flush     = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         hs = req_valid & req_ready;
         tick();
      end
      drain();
   endtask

   initial begin
      reset_n = 1'b0; req_valid = 2'b00; req_sub = 2'b00; req_rm0 = 3'd0; req_rm1 = 3'd0;
      req_id0 = '0; req_id1 = '0; flush = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      test_reset();
      test_latency();
      test_fairness();
      test_backpressure();
      test_flush();
      test_flush_stall();
      test_random();
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
